in_reg_bank: RTL and testbench

- Parametrised multi-channel successor to the single-bit IO input register cell.
- Each channel has:
  - a configurable synchroniser chain;
  - an optional hold-fix retiming stage;
  - a consecutive-sample glitch filter;
  - rise/fall edge pulses;
  - a per-channel combinational bypass.
- Sits between the IO pads (A2F side) and fabric logic that needs clean, synchronised, debounced inputs.

---
 rtl/in_reg_bank.sv | 130 +++++++++++++
 tb/tb_in_reg_bank.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/in_reg_bank.sv
// in_reg_bank: multi-channel pad input register bank.
// Each channel runs the pad input through a synchroniser chain, an optional
// hold-fix retiming flop, a consecutive-sample glitch filter and rise/fall
// edge pulse generation. A per-channel bypass shows the raw pad value on IQZ.
module in_reg_bank #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      FILTER_LEN  = 3,
  parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}}
) (
  input  logic             IQC,
  input  logic             QRT_N,
  input  logic             IQE,
  input  logic [WIDTH-1:0] ISEL,
  input  logic [WIDTH-1:0] FIXHOLD,
  input  logic [WIDTH-1:0] A2F,
  output logic [WIDTH-1:0] IQZ,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
);

  // Counter wide enough for 0..FILTER_LEN-1; a FILTER_LEN of 1 still gets one bit.
  localparam int unsigned    CW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_LEN - 1);

  logic [WIDTH-1:0] sync_out_s;
  logic [WIDTH-1:0] hold_d, hold_q;
  logic [WIDTH-1:0] samp_s;
  logic [WIDTH-1:0] filt_d, filt_q;
  logic [WIDTH-1:0] rise_d, rise_q;
  logic [WIDTH-1:0] fall_d, fall_q;
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [CW-1:0]    cnt_q [WIDTH];

  // Synchroniser chain; free-running so settling time never depends on IQE.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign sync_out_s = A2F;
  end else begin : g_sync
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    // Shift the pad value one stage down the chain each edge.
    always_comb begin
      sync_d[0] = A2F;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_d[i] = sync_q[i-1];
      end
    end

    // Synchroniser flops.
    always_ff @(posedge IQC or negedge QRT_N) begin
      if (!QRT_N) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
          sync_q[i] <= RESET_VAL;
        end
      end else begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_d[i];
        end
      end
    end

    assign sync_out_s = sync_q[SYNC_STAGES-1];
  end

  // Hold-fix flop always samples the chain so FIXHOLD can switch without losing data.
  always_comb begin
    hold_d = sync_out_s;
  end

  // Hold-fix retiming flop.
  always_ff @(posedge IQC or negedge QRT_N) begin
    if (!QRT_N) begin
      hold_q <= RESET_VAL;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign samp_s = (FIXHOLD & hold_q) | (~FIXHOLD & sync_out_s);

  // Glitch filter: a differing sample must persist FILTER_LEN enabled edges.
  always_comb begin
    filt_d = filt_q;
    rise_d = {WIDTH{1'b0}};
    fall_d = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (IQE) begin
        if (samp_s[i] == filt_q[i]) begin
          cnt_d[i] = {CW{1'b0}};
        end else if (cnt_q[i] == CNT_MAX) begin
          filt_d[i] = samp_s[i];
          cnt_d[i]  = {CW{1'b0}};
          rise_d[i] = samp_s[i];
          fall_d[i] = ~samp_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Filter value, persistence counters and edge-pulse registers.
  always_ff @(posedge IQC or negedge QRT_N) begin
    if (!QRT_N) begin
      filt_q <= RESET_VAL;
      rise_q <= {WIDTH{1'b0}};
      fall_q <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= {CW{1'b0}};
      end
    end else begin
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Bypassed channels show the pad directly and suppress their pulses.
  assign IQZ  = (ISEL & A2F) | (~ISEL & filt_q);
  assign RISE = rise_q & ~ISEL;
  assign FALL = fall_q & ~ISEL;

endmodule

// File: tb/tb_in_reg_bank.sv
// Testbench for in_reg_bank: directed test-plan steps followed by a random
// phase, all compared against a delay-line / run-length reference model.
module tb_in_reg_bank;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int FL   = 3;

  logic         IQC;
  logic         QRT_N;
  logic         IQE;
  logic [W-1:0] ISEL;
  logic [W-1:0] FIXHOLD;
  logic [W-1:0] A2F;
  logic [W-1:0] IQZ;
  logic [W-1:0] RISE;
  logic [W-1:0] FALL;

  int checks = 0;
  int errors = 0;

  // Reference model: past pad samples, filtered value, run lengths, pulses.
  logic [W-1:0] hist [0:7];
  logic [W-1:0] f_m;
  logic [W-1:0] rise_m;
  logic [W-1:0] fall_m;
  int           run_m [W];

  in_reg_bank #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .FILTER_LEN(FL), .RESET_VAL(4'h0)
  ) dut (
    .IQC(IQC), .QRT_N(QRT_N), .IQE(IQE),
    .ISEL(ISEL), .FIXHOLD(FIXHOLD), .A2F(A2F),
    .IQZ(IQZ), .RISE(RISE), .FALL(FALL)
  );

  initial begin
    IQC = 1'b0;
    forever #5 IQC = ~IQC;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) hist[i] = 4'h0;
    f_m    = 4'h0;
    rise_m = 4'h0;
    fall_m = 4'h0;
    for (int c = 0; c < W; c++) run_m[c] = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    logic s;
    int   k;
    if (!QRT_N) begin
      model_reset();
    end else begin
      for (int c = 0; c < W; c++) begin
        k = SYNC + (FIXHOLD[c] ? 1 : 0);
        s = (k == 0) ? A2F[c] : hist[k-1][c];
        rise_m[c] = 1'b0;
        fall_m[c] = 1'b0;
        if (IQE) begin
          if (s == f_m[c]) begin
            run_m[c] = 0;
          end else begin
            run_m[c] = run_m[c] + 1;
            if (run_m[c] == FL) begin
              f_m[c]    = s;
              run_m[c]  = 0;
              rise_m[c] = s;
              fall_m[c] = ~s;
            end
          end
        end
      end
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = A2F;
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_iqz"},  IQZ,  (ISEL & A2F) | (~ISEL & f_m));
    chk({tag, "_rise"}, RISE, rise_m & ~ISEL);
    chk({tag, "_fall"}, FALL, fall_m & ~ISEL);
  endtask

  task automatic tick(input string tag);
    @(posedge IQC);
    model_step();
    #1;
    check_model(tag);
  endtask

  initial begin
    QRT_N   = 1'b0;
    A2F     = 4'hF;
    ISEL    = 4'h0;
    FIXHOLD = 4'h0;
    IQE     = 1'b1;
    model_reset();

    // Reset held with pads high
    tick("rst");
    tick("rst");
    chk("rst_iqz",  IQZ,  4'h0);
    chk("rst_rise", RISE, 4'h0);
    chk("rst_fall", FALL, 4'h0);

    // Release: IQZ appears 5 edges later with a one-cycle RISE
    #2 QRT_N = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick("rel");
      chk("rel_iqz",  IQZ,  (k >= 5) ? 4'hF : 4'h0);
      chk("rel_rise", RISE, (k == 5) ? 4'hF : 4'h0);
    end

    // Bring all channels low
    A2F = 4'h0;
    repeat (8) tick("low");

    // Two-cycle glitch on channel 0 is filtered out
    A2F = 4'h1;
    tick("gl");
    tick("gl");
    A2F = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      tick("gl");
      chk("glitch_iqz0",  {3'b000, IQZ[0]},  4'h0);
      chk("glitch_rise0", {3'b000, RISE[0]}, 4'h0);
    end

    // Three-cycle pulse passes; FALL follows after the return low
    A2F = 4'h1;
    for (int k = 1; k <= 12; k++) begin
      tick("pass");
      if (k == 3) A2F = 4'h0;
      chk("pass_iqz0",  {3'b000, IQZ[0]},  (k >= 5 && k < 8) ? 4'h1 : 4'h0);
      chk("pass_rise0", {3'b000, RISE[0]}, (k == 5) ? 4'h1 : 4'h0);
      chk("pass_fall0", {3'b000, FALL[0]}, (k == 8) ? 4'h1 : 4'h0);
    end

    // Bypass on channel 0 follows the pad combinationally
    ISEL = 4'b0001;
    A2F  = 4'h0;
    #2 A2F = 4'h1;
    #1;
    chk("byp_hi_iqz0",  {3'b000, IQZ[0]},  4'h1);
    chk("byp_hi_rise0", {3'b000, RISE[0]}, 4'h0);
    A2F = 4'h0;
    #1;
    chk("byp_lo_iqz0", {3'b000, IQZ[0]}, 4'h0);
    A2F = 4'h1;
    for (int k = 1; k <= 8; k++) begin
      tick("byp");
      chk("byp_rise0", {3'b000, RISE[0]}, 4'h0);
    end
    #3 ISEL = 4'h0;
    #1;
    chk("byp_clr_iqz0", {3'b000, IQZ[0]}, 4'h1);
    check_model("byp_clr");

    // Hold-fix on channel 1 delays it one edge behind channel 2
    FIXHOLD = 4'b0010;
    A2F     = 4'b0111;
    for (int k = 1; k <= 7; k++) begin
      tick("hf");
      chk("hf_iqz2",  {3'b000, IQZ[2]},  (k >= 5) ? 4'h1 : 4'h0);
      chk("hf_iqz1",  {3'b000, IQZ[1]},  (k >= 6) ? 4'h1 : 4'h0);
      chk("hf_rise2", {3'b000, RISE[2]}, (k == 5) ? 4'h1 : 4'h0);
      chk("hf_rise1", {3'b000, RISE[1]}, (k == 6) ? 4'h1 : 4'h0);
    end

    // Capture enable dropped part-way through channel 3's persistence count
    FIXHOLD = 4'h0;
    A2F     = 4'hF;
    repeat (3) tick("ce");
    IQE = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick("ce_off");
      chk("ce_off_iqz3", {3'b000, IQZ[3]}, 4'h0);
      chk("ce_off_rise", RISE, 4'h0);
      chk("ce_off_fall", FALL, 4'h0);
    end
    IQE = 1'b1;
    tick("ce_on");
    chk("ce_on1_iqz3", {3'b000, IQZ[3]}, 4'h0);
    tick("ce_on");
    chk("ce_on2_iqz3", {3'b000, IQZ[3]}, 4'h1);
    chk("ce_on2_rise", RISE, 4'b1000);

    // Asynchronous reset mid-count on channel 0
    A2F = 4'hE;
    repeat (4) tick("mid");
    #2 QRT_N = 1'b0;
    model_reset();
    #1;
    chk("arst_iqz",  IQZ,  4'h0);
    chk("arst_rise", RISE, 4'h0);
    chk("arst_fall", FALL, 4'h0);
    A2F = 4'h0;
    tick("arst");
    tick("arst");
    #2 QRT_N = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick("post");
      chk("post_rise", RISE, 4'h0);
      chk("post_fall", FALL, 4'h0);
    end

    // Random phase against the model
    for (int n = 0; n < 600; n++) begin
      tick("rand");
      for (int c = 0; c < W; c++) begin
        if ($urandom_range(3) == 0) A2F[c] = ~A2F[c];
      end
      IQE = ($urandom_range(9) != 0);
      if ($urandom_range(15) == 0) ISEL = ($urandom_range(2) == 0) ? W'($urandom) : 4'h0;
      if ($urandom_range(25) == 0) FIXHOLD = W'($urandom);
      if ($urandom_range(99) == 0) begin
        #2 QRT_N = 1'b0;
        model_reset();
        #1;
        check_model("rand_arst");
        #2 QRT_N = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
